// File: rtl/simmem_pkg.sv
// Shared types, default sizing and the free-slot search used by simmem_delay_bank.
package simmem_pkg;

  localparam int unsigned DefNumSlots   = 16;
  localparam int unsigned DefIdWidth    = 4;
  localparam int unsigned DefDelayWidth = 8;
  localparam int          MaxSlots      = 64;

  typedef logic [DefDelayWidth-1:0] delay_t;
  typedef logic [DefIdWidth-1:0]    id_t;

  // Lowest set bit of a free mask; callers only use the result when some bit is set.
  function automatic int lowest_free_idx(input logic [MaxSlots-1:0] free_vec);
    int idx;
    idx = 0;
    for (int i = MaxSlots - 1; i >= 0; i--) begin
      if (free_vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/simmem_delay_bank_if.sv
// Request/release handshake bundle between the AXI front end, the delay bank and the message banks.
interface simmem_delay_bank_if #(
  parameter int unsigned IDWidth    = simmem_pkg::DefIdWidth,
  parameter int unsigned DelayWidth = simmem_pkg::DefDelayWidth
);

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [IDWidth-1:0]    in_id_i;
  logic [DelayWidth-1:0] in_delay_i;
  logic                  release_valid_o;
  logic                  release_ready_i;
  logic [IDWidth-1:0]    release_id_o;

  modport master (
    output in_valid_i, in_id_i, in_delay_i, release_ready_i,
    input  in_ready_o, release_valid_o, release_id_o
  );

  modport slave (
    input  in_valid_i, in_id_i, in_delay_i, release_ready_i,
    output in_ready_o, release_valid_o, release_id_o
  );

endinterface

// File: rtl/simmem_age_matrix.sv
// Allocation-order matrix: older[i][j]=1 when slot i was allocated before slot j, plus oldest-of-mask select.
module simmem_age_matrix #(
  parameter int unsigned NumSlots = simmem_pkg::DefNumSlots
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumSlots-1:0]                alloc_oh,
  input  logic [NumSlots-1:0]                free_oh,
  input  logic [NumSlots-1:0]                valid_vec,
  input  logic [NumSlots-1:0]                select_mask,
  output logic [NumSlots-1:0][NumSlots-1:0]  older,
  output logic [NumSlots-1:0]                oldest_oh
);

  logic [NumSlots-1:0][NumSlots-1:0] older_q, older_d;

  // A new slot is younger than every currently valid slot; freeing clears its row and column.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < NumSlots; i++) begin
      for (int j = 0; j < NumSlots; j++) begin
        if (alloc_oh[i]) older_d[i][j] = 1'b0;
        if (alloc_oh[j] && valid_vec[i] && (i != j)) older_d[i][j] = 1'b1;
        if (free_oh[i] || free_oh[j]) older_d[i][j] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) older_q <= '0;
    else         older_q <= older_d;
  end

  always_comb begin
    oldest_oh = '0;
    for (int i = 0; i < NumSlots; i++) begin
      oldest_oh[i] = select_mask[i];
      for (int j = 0; j < NumSlots; j++) begin
        if (select_mask[j] && older_q[j][i]) oldest_oh[i] = 1'b0;
      end
    end
  end

  assign older = older_q;

endmodule

// File: rtl/simmem_delay_bank.sv
// Per-request delay slots with in-order per-ID release; oldest eligible slot is offered downstream.
// Optional occupancy statistics ports are enabled by SIMMEM_DELAY_BANK_STATS_EN.
module simmem_delay_bank
  import simmem_pkg::*;
#(
  parameter int unsigned NumSlots   = DefNumSlots,
  parameter int unsigned IDWidth    = DefIdWidth,
  parameter int unsigned DelayWidth = DefDelayWidth
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  simmem_delay_bank_if.slave               bus
`ifdef SIMMEM_DELAY_BANK_STATS_EN
  ,
  output logic [$clog2(NumSlots+1)-1:0]    occupancy_o,
  output logic [$clog2(NumSlots+1)-1:0]    max_occupancy_o
`endif
);

  logic [NumSlots-1:0]               valid_q;
  logic [IDWidth-1:0]                id_q  [NumSlots];
  logic [DelayWidth-1:0]             cnt_q [NumSlots];
  logic [NumSlots-1:0][NumSlots-1:0] older;
  logic [NumSlots-1:0]               alloc_oh, free_oh, eligible, release_oh;
  logic [IDWidth-1:0]                release_id;
  logic                              in_accept, release_fire;
  int                                free_idx;

  assign bus.in_ready_o      = ~&valid_q;
  assign in_accept           = bus.in_valid_i && bus.in_ready_o;
  assign bus.release_valid_o = |eligible;
  assign release_fire        = bus.release_valid_o && bus.release_ready_i;
  assign free_oh             = release_oh & {NumSlots{release_fire}};
  assign bus.release_id_o    = release_id;

  always_comb begin
    free_idx = lowest_free_idx(MaxSlots'(~valid_q));
    alloc_oh = '0;
    for (int i = 0; i < NumSlots; i++) begin
      alloc_oh[i] = in_accept && (free_idx == i);
    end
  end

  // A slot is held back while an older valid slot carries the same ID.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NumSlots; i++) begin
      eligible[i] = valid_q[i] && (cnt_q[i] == '0);
      for (int j = 0; j < NumSlots; j++) begin
        if (valid_q[j] && older[j][i] && (id_q[j] == id_q[i])) eligible[i] = 1'b0;
      end
    end
  end

  always_comb begin
    release_id = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (release_oh[i]) release_id = release_id | id_q[i];
    end
  end

  simmem_age_matrix #(.NumSlots(NumSlots)) u_age (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .alloc_oh    (alloc_oh),
    .free_oh     (free_oh),
    .valid_vec   (valid_q),
    .select_mask (eligible),
    .older       (older),
    .oldest_oh   (release_oh)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        if (alloc_oh[i]) begin
          valid_q[i] <= 1'b1;
          id_q[i]    <= bus.in_id_i;
          cnt_q[i]   <= bus.in_delay_i;
        end else begin
          if (free_oh[i]) valid_q[i] <= 1'b0;
          if (valid_q[i] && (cnt_q[i] != '0)) cnt_q[i] <= cnt_q[i] - DelayWidth'(1);
        end
      end
    end
  end

`ifdef SIMMEM_DELAY_BANK_STATS_EN
  localparam int unsigned OccWidth = $clog2(NumSlots + 1);

  logic [OccWidth-1:0] occ_q, max_q, occ_d;

  assign occ_d = occ_q + OccWidth'(in_accept) - OccWidth'(release_fire);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occ_q <= '0;
      max_q <= '0;
    end else begin
      occ_q <= occ_d;
      if (occ_d > max_q) max_q <= occ_d;
    end
  end

  assign occupancy_o     = occ_q;
  assign max_occupancy_o = max_q;
`endif

endmodule

// File: tb/tb_simmem_delay_bank.sv
// Directed self-checking bench for simmem_delay_bank (stats ports checked when SIMMEM_DELAY_BANK_STATS_EN is set).
module tb_simmem_delay_bank;
  import simmem_pkg::*;

  localparam int unsigned NSlots = DefNumSlots;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0;
  int   n;

  always #5 clk_i = ~clk_i;

  simmem_delay_bank_if #(.IDWidth(DefIdWidth), .DelayWidth(DefDelayWidth)) bus ();

`ifdef SIMMEM_DELAY_BANK_STATS_EN
  logic [$clog2(NSlots+1)-1:0] occupancy, max_occupancy;
`endif

  simmem_delay_bank #(
    .NumSlots   (NSlots),
    .IDWidth    (DefIdWidth),
    .DelayWidth (DefDelayWidth)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .bus             (bus.slave)
`ifdef SIMMEM_DELAY_BANK_STATS_EN
    ,
    .occupancy_o     (occupancy),
    .max_occupancy_o (max_occupancy)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic send(input id_t id, input delay_t d);
    bus.in_valid_i = 1'b1;
    bus.in_id_i    = id;
    bus.in_delay_i = d;
    step();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_rel(input int limit);
    n = 0;
    while (!bus.release_valid_o && n < limit) begin
      step();
      n++;
    end
  endtask

  initial begin
    bus.in_valid_i      = 1'b1;
    bus.in_id_i         = 4'hA;
    bus.in_delay_i      = '0;
    bus.release_ready_i = 1'b1;

    // reset with a request held
    step();
    step();
    chk("rst_in_ready", bus.in_ready_o, 1);
    chk("rst_rel_valid", bus.release_valid_o, 0);
    chk("rst_rel_id", bus.release_id_o, 0);
`ifdef SIMMEM_DELAY_BANK_STATS_EN
    chk("rst_occ", occupancy, 0);
    chk("rst_max_occ", max_occupancy, 0);
`endif
    bus.in_valid_i = 1'b0;
    rst_ni         = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("idle_no_release", bus.release_valid_o, 0);
    end

    // single request, delay 5
    t0 = cyc;
    send(4'd3, 8'd5);
    wait_rel(20);
    chk("id3_latency", cyc - t0, 6);
    chk("id3_id", bus.release_id_o, 3);
    step();
    chk("id3_one_cycle", bus.release_valid_o, 0);

    // same ID, later request shorter delay
    t0 = cyc;
    send(4'd2, 8'd10);
    send(4'd2, 8'd0);
    wait_rel(30);
    chk("id2_first_latency", cyc - t0, 11);
    chk("id2_first_id", bus.release_id_o, 2);
    step();
    chk("id2_second_valid", bus.release_valid_o, 1);
    chk("id2_second_id", bus.release_id_o, 2);
    step();
    chk("id2_drained", bus.release_valid_o, 0);

    // different IDs overtake
    t0 = cyc;
    send(4'd1, 8'd4);
    send(4'd5, 8'd0);
    chk("id5_valid_c2", bus.release_valid_o, 1);
    chk("id5_id", bus.release_id_o, 5);
    step();
    wait_rel(10);
    chk("id1_latency", cyc - t0, 5);
    chk("id1_id", bus.release_id_o, 1);
    step();
    chk("id1_drained", bus.release_valid_o, 0);

    // backpressure with two eligible slots
    bus.release_ready_i = 1'b0;
    send(4'd7, 8'd0);
    send(4'd9, 8'd0);
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", bus.release_valid_o, 1);
      chk("hold_id", bus.release_id_o, 7);
`ifdef SIMMEM_DELAY_BANK_STATS_EN
      chk("hold_occ", occupancy, 2);
`endif
      step();
    end
    bus.release_ready_i = 1'b1;
    step();
    chk("drain_second_valid", bus.release_valid_o, 1);
    chk("drain_second_id", bus.release_id_o, 9);
`ifdef SIMMEM_DELAY_BANK_STATS_EN
    chk("drain_occ1", occupancy, 1);
`endif
    step();
    chk("drain_empty", bus.release_valid_o, 0);
`ifdef SIMMEM_DELAY_BANK_STATS_EN
    chk("drain_occ0", occupancy, 0);
`endif

    // fill all slots, extra request refused
    t0 = cyc;
    for (int i = 0; i < int'(NSlots); i++) send(id_t'(i), 8'd255);
    chk("full_in_ready", bus.in_ready_o, 0);
`ifdef SIMMEM_DELAY_BANK_STATS_EN
    chk("full_occ", occupancy, NSlots);
`endif
    bus.in_valid_i = 1'b1;
    bus.in_id_i    = 4'd5;
    bus.in_delay_i = 8'd0;
    step();
    bus.in_valid_i = 1'b0;
    chk("full_still_not_ready", bus.in_ready_o, 0);
    chk("full_no_release", bus.release_valid_o, 0);
    wait_rel(300);
    chk("full_first_latency", cyc - t0, 256);
    chk("full_first_id", bus.release_id_o, 0);
    chk("full_ready_before_edge", bus.in_ready_o, 0);
    step();
    chk("full_ready_after_release", bus.in_ready_o, 1);
    for (int k = 1; k < int'(NSlots); k++) begin
      chk("full_drain_valid", bus.release_valid_o, 1);
      chk("full_drain_id", bus.release_id_o, k);
      step();
    end
    chk("full_drain_empty", bus.release_valid_o, 0);
`ifdef SIMMEM_DELAY_BANK_STATS_EN
    chk("full_max_occ", max_occupancy, NSlots);
`endif

    // reset mid-operation drops pending slots
    bus.release_ready_i = 1'b0;
    send(4'd4, 8'd0);
    send(4'd6, 8'd0);
    chk("midrst_pre_valid", bus.release_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid", bus.release_valid_o, 0);
    chk("midrst_id", bus.release_id_o, 0);
    chk("midrst_in_ready", bus.in_ready_o, 1);
    step();
    rst_ni              = 1'b1;
    bus.release_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("midrst_no_release", bus.release_valid_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
